// File: rtl/fpmul_op_driver.sv
// Operand driver for the FP multiplier test interface: buffers (A, B) pairs,
// issues them one at a time over op_valid/op_ready and collects each result over res_valid/res_ready.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
// Once valid is raised, it and the data stay stable until that edge.
module fpmul_op_driver #(
    parameter int DW      = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_valid,
    input  logic [DW-1:0]              ld_a,
    input  logic [DW-1:0]              ld_b,
    output logic                       ld_ready,
    input  logic                       start,
    output logic [DW-1:0]              a_out,
    output logic [DW-1:0]              b_out,
    output logic                       op_valid,
    input  logic                       op_ready,
    input  logic [DW-1:0]              res_data,
    input  logic                       res_valid,
    output logic                       res_ready,
    output logic [DW-1:0]              res_out,
    output logic                       res_out_valid,
    output logic [$clog2(DEPTH+1)-1:0] sent_cnt,
    output logic [$clog2(DEPTH+1)-1:0] recv_cnt,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout_err,
    output logic [1:0]                 state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RES, ERR} state_t;

    state_t          state, state_nx;
    logic [DW-1:0]   mem_a [DEPTH];
    logic [DW-1:0]   mem_b [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [TW-1:0]   timer;
    logic            load_fire, op_fire, res_fire, pop, start_go, timed_out;

    assign ld_ready  = rst && (state == IDLE) && (count < CW'(DEPTH));
    assign load_fire = ld_valid && ld_ready;
    assign op_fire   = op_valid && op_ready;
    assign res_fire  = res_valid && res_ready;
    assign pop       = (state == SEND) && op_fire;
    assign start_go  = (state == IDLE) && start && ((count != '0) || load_fire);
    // A result arriving on the final timer cycle takes priority over the timeout.
    assign timed_out = (state == WAIT_RES) && !res_fire && (timer == TW'(TIMEOUT - 1));
    assign busy      = (state == SEND) || (state == WAIT_RES);
    assign state_dbg = state;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start_go) state_nx = SEND;
            SEND:     if (op_fire) state_nx = WAIT_RES;
            WAIT_RES: begin
                if (res_fire)       state_nx = (count == '0) ? IDLE : SEND;
                else if (timed_out) state_nx = ERR;
            end
            default:  state_nx = ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem_a[wr_ptr] <= ld_a;
            mem_b[wr_ptr] <= ld_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (load_fire) wr_ptr <= wr_ptr + AW'(1);
            if (pop)       rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(load_fire) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_out         <= '0;
            b_out         <= '0;
            op_valid      <= 1'b0;
            res_ready     <= 1'b0;
            res_out       <= '0;
            res_out_valid <= 1'b0;
            sent_cnt      <= '0;
            recv_cnt      <= '0;
            done          <= 1'b0;
            timeout_err   <= 1'b0;
            timer         <= '0;
        end else begin
            res_out_valid <= 1'b0;
            done          <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_go) begin
                        sent_cnt <= '0;
                        recv_cnt <= '0;
                        op_valid <= 1'b1;
                        // With an empty buffer the head is the pair being loaded right now.
                        a_out    <= (count != '0) ? mem_a[rd_ptr] : ld_a;
                        b_out    <= (count != '0) ? mem_b[rd_ptr] : ld_b;
                    end
                end
                SEND: begin
                    if (op_fire) begin
                        op_valid  <= 1'b0;
                        res_ready <= 1'b1;
                        timer     <= '0;
                        sent_cnt  <= (sent_cnt == CW'(DEPTH)) ? sent_cnt : sent_cnt + CW'(1);
                    end
                end
                WAIT_RES: begin
                    timer <= timer + TW'(1);
                    if (res_fire) begin
                        res_out       <= res_data;
                        res_out_valid <= 1'b1;
                        res_ready     <= 1'b0;
                        recv_cnt      <= (recv_cnt == CW'(DEPTH)) ? recv_cnt : recv_cnt + CW'(1);
                        if (count == '0) begin
                            done <= 1'b1;
                        end else begin
                            a_out    <= mem_a[rd_ptr];
                            b_out    <= mem_b[rd_ptr];
                            op_valid <= 1'b1;
                        end
                    end else if (timed_out) begin
                        timeout_err <= 1'b1;
                        res_ready   <= 1'b0;
                    end
                end
                default: begin
                    op_valid  <= 1'b0;
                    res_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpmul_op_driver.sv
// Directed bench for fpmul_op_driver: a responder multiplies by 2.0 via exponent increment,
// and captured results are compared against hand-computed products in an expected queue.
module tb_fpmul_op_driver;
    localparam logic [31:0] F2  = 32'h4000_0000;
    localparam logic [31:0] F3  = 32'h4040_0000;
    localparam logic [31:0] F5  = 32'h40A0_0000;
    localparam logic [31:0] F6  = 32'h40C0_0000;
    localparam logic [31:0] F7  = 32'h40E0_0000;
    localparam logic [31:0] F9  = 32'h4110_0000;
    localparam logic [31:0] F10 = 32'h4120_0000;
    localparam logic [31:0] F14 = 32'h4160_0000;

    // A = 1.0 .. 8.0, and the products A * 2.0 = 2.0 .. 16.0
    logic [31:0] ops  [8] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                              32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
    logic [31:0] prods[8] = '{32'h4000_0000, 32'h4080_0000, 32'h40C0_0000, 32'h4100_0000,
                              32'h4120_0000, 32'h4140_0000, 32'h4160_0000, 32'h4180_0000};

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid, start, op_ready, res_valid;
    logic [31:0] ld_a, ld_b, res_data;
    logic        ld_ready, op_valid, res_ready, res_out_valid, busy, done, timeout_err;
    logic [31:0] a_out, b_out, res_out;
    logic [3:0]  sent_cnt, recv_cnt;
    logic [1:0]  state_dbg;

    logic        resp_en;
    int          resp_delay;
    logic [31:0] cap;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    fpmul_op_driver #(.DW(32), .DEPTH(8), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_a(ld_a), .ld_b(ld_b),
        .ld_ready(ld_ready), .start(start), .a_out(a_out), .b_out(b_out),
        .op_valid(op_valid), .op_ready(op_ready), .res_data(res_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out),
        .res_out_valid(res_out_valid), .sent_cnt(sent_cnt), .recv_cnt(recv_cnt),
        .busy(busy), .done(done), .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] b);
        ld_valid = 1'b1; ld_a = a; ld_b = b;
        check("ld_ready_load", ld_ready, 1'b1);
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (done) break;
            tick();
        end
        check(tag, done, 1'b1);
    endtask

    task automatic score(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check(tag, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    always @(negedge clk) if (res_out_valid) got_q.push_back(res_out);

    // Responder: answers each operand handshake resp_delay cycles later with A * 2.0.
    initial begin
        res_valid = 1'b0;
        res_data  = '0;
        forever begin
            @(posedge clk);
            if (resp_en && rst && op_valid && op_ready) begin
                cap = a_out;
                repeat (resp_delay - 1) @(posedge clk);
                #1;
                res_valid = 1'b1;
                res_data  = cap + 32'h0080_0000;
                for (int i = 0; i < 200; i++) begin
                    @(posedge clk);
                    if (res_ready) break;
                end
                #1;
                res_valid = 1'b0;
            end
        end
    end

    initial begin
        rst = 1'b0; ld_valid = 1'b0; start = 1'b0; op_ready = 1'b1;
        ld_a = '0; ld_b = '0; resp_en = 1'b1; resp_delay = 2;
        tick(); tick();
        check("rst_ld_ready", ld_ready, 1'b0);
        check("rst_op_valid", op_valid, 1'b0);
        check("rst_res_ready", res_ready, 1'b0);
        check("rst_a_out", a_out, 32'h0);
        check("rst_sent", sent_cnt, 4'd0);
        check("rst_err", timeout_err, 1'b0);
        rst = 1'b1;
        #1;
        check("idle_ld_ready", ld_ready, 1'b1);

        // 3.0 * 2.0 with a two-cycle responder
        load(F3, F2);
        kick();
        check("t1_op_valid", op_valid, 1'b1);
        check("t1_a_out", a_out, F3);
        check("t1_b_out", b_out, F2);
        check("t1_busy", busy, 1'b1);
        tick();
        check("t1_op_dropped", op_valid, 1'b0);
        check("t1_res_ready", res_ready, 1'b1);
        check("t1_sent", sent_cnt, 4'd1);
        tick(); tick();
        check("t1_res_strobe", res_out_valid, 1'b1);
        check("t1_res_out", res_out, F6);
        check("t1_done", done, 1'b1);
        check("t1_recv", recv_cnt, 4'd1);
        tick();
        check("t1_strobe_end", res_out_valid, 1'b0);
        check("t1_done_end", done, 1'b0);
        check("t1_idle", busy, 1'b0);
        check("t1_hold_recv", recv_cnt, 4'd1);
        exp_q.push_back(F6);
        score("t1_res");

        // Fill all 8 entries, refuse a 9th, then run twice so the pointers wrap
        for (int i = 0; i < 8; i++) load(ops[i], F2);
        ld_valid = 1'b1; ld_a = F9; ld_b = F2;
        #1;
        check("t2_full_ld_ready", ld_ready, 1'b0);
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(prods[i]);
        kick();
        wait_done("t2_done1");
        check("t2_sent", sent_cnt, 4'd8);
        check("t2_recv", recv_cnt, 4'd8);
        tick();
        score("t2_run1");
        kick();
        check("t2_empty_start", busy, 1'b0);
        for (int i = 7; i >= 0; i--) load(ops[i], F2);
        for (int i = 7; i >= 0; i--) exp_q.push_back(prods[i]);
        kick();
        wait_done("t2_done2");
        tick();
        score("t2_run2");

        // Back-pressure: operands hold for 5 cycles, one pop on release
        op_ready = 1'b0;
        load(F5, F2);
        kick();
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", op_valid, 1'b1);
            check("t3_hold_a", a_out, F5);
            check("t3_hold_b", b_out, F2);
            check("t3_hold_sent", sent_cnt, 4'd0);
            tick();
        end
        op_ready = 1'b1;
        tick();
        check("t3_popped", op_valid, 1'b0);
        check("t3_sent", sent_cnt, 4'd1);
        exp_q.push_back(F10);
        wait_done("t3_done");
        tick();
        score("t3_res");

        // Result on the very last timer cycle beats the timeout
        resp_delay = 64;
        load(F3, F2);
        kick();
        exp_q.push_back(F6);
        wait_done("t3b_done");
        check("t3b_no_err", timeout_err, 1'b0);
        tick();
        score("t3b_res");
        resp_delay = 2;

        // No response: error after 64 cycles in WAIT_RES
        resp_en = 1'b0;
        load(F3, F2);
        kick();
        tick();
        repeat (63) tick();
        check("t4_not_yet", timeout_err, 1'b0);
        check("t4_busy_wait", busy, 1'b1);
        tick();
        check("t4_err", timeout_err, 1'b1);
        check("t4_busy", busy, 1'b0);
        check("t4_ld_ready", ld_ready, 1'b0);
        check("t4_res_ready", res_ready, 1'b0);
        check("t4_state", state_dbg, 2'd3);
        ld_valid = 1'b1; ld_a = F7; ld_b = F2; start = 1'b1;
        tick();
        ld_valid = 1'b0; start = 1'b0;
        check("t4_start_ignored", op_valid, 1'b0);
        check("t4_sticky", timeout_err, 1'b1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("t4_cleared", timeout_err, 1'b0);

        // Reset in WAIT_RES with 3 pairs pending
        for (int i = 0; i < 4; i++) load(ops[i], F2);
        kick();
        tick(); tick();
        check("t5_waiting", res_ready, 1'b1);
        rst = 1'b0;
        tick();
        check("t5_rst_ld_ready", ld_ready, 1'b0);
        check("t5_rst_res_ready", res_ready, 1'b0);
        check("t5_rst_a_out", a_out, 32'h0);
        check("t5_rst_b_out", b_out, 32'h0);
        check("t5_rst_sent", sent_cnt, 4'd0);
        check("t5_rst_busy", busy, 1'b0);
        rst = 1'b1;
        #1;
        check("t5_ld_ready", ld_ready, 1'b1);
        kick();
        check("t5_empty_start", busy, 1'b0);
        check("t5_no_op", op_valid, 1'b0);

        // Load and start together on an empty buffer
        resp_en = 1'b1;
        got_q.delete();
        ld_valid = 1'b1; ld_a = F7; ld_b = F2; start = 1'b1;
        #1;
        check("t6_ld_ready", ld_ready, 1'b1);
        tick();
        ld_valid = 1'b0; start = 1'b0;
        check("t6_op_valid", op_valid, 1'b1);
        check("t6_a_out", a_out, F7);
        check("t6_b_out", b_out, F2);
        exp_q.push_back(F14);
        wait_done("t6_done");
        tick();
        score("t6_res");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fpmul_op_driver.md
Name: fpmul_op_driver

Overview:
- Initiator side of the FP multiplier valid/ready test interface.
- Buffers operand pairs (A, B) loaded by a controller and sends them one at a time over the operand handshake.
- Waits for each result on the result handshake, then forwards the captured result with a one-cycle strobe.
- Keeps sent/received counters and flags a response timeout; intended for synthesizable self-test around the multiplier wrapper.

Parameters:
DW, 32, operand/result width (IEEE-754 single)
DEPTH, 8, operand-pair buffer entries (power of 2, >=2)
TIMEOUT, 64, max cycles in WAIT_RES before error (>=4)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low
ld_valid  in  1  load request for one operand pair
ld_a  in  DW  operand A to load
ld_b  in  DW  operand B to load
ld_ready  out  1  buffer accepts a pair this cycle
start  in  1  begin transmitting buffered pairs
a_out  out  DW  operand A toward multiplier
b_out  out  DW  operand B toward multiplier
op_valid  out  1  a_out/b_out valid
op_ready  in  1  multiplier accepts operands
res_data  in  DW  result from multiplier
res_valid  in  1  res_data valid
res_ready  out  1  driver accepts result
res_out  out  DW  last captured result
res_out_valid  out  1  one-cycle strobe, res_out updated
sent_cnt  out  $clog2(DEPTH+1)  pairs sent since start
recv_cnt  out  $clog2(DEPTH+1)  results received since start
busy  out  1  state is SEND or WAIT_RES
done  out  1  one-cycle pulse, all buffered pairs completed
timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst==0 at an edge):
  - State IDLE; buffer emptied (rd/wr pointers and count 0).
  - All registered outputs 0: a_out, b_out, res_out, op_valid, res_ready, res_out_valid, counters, done, timeout_err.
  - ld_ready is 0 while rst==0.
  - Reset mid-transfer aborts immediately; no further handshake that cycle.
- ld_ready is combinational: rst && state==IDLE && count<DEPTH.
  - A pair is written on ld_valid && ld_ready.
  - Loads outside IDLE or when full are refused (ld_ready=0); buffer contents unchanged.
- State IDLE:
  - start && (count>0 || load accepted same cycle) -> SEND.
  - On that same edge: sent_cnt/recv_cnt cleared, a_out/b_out <= head pair (or the pair being loaded if the buffer was empty), op_valid <= 1.
  - start with empty buffer and no load: ignored.
- State SEND:
  - op_valid stays 1; a_out/b_out held stable until op_valid && op_ready at an edge.
  - On that handshake: pop head, sent_cnt++, op_valid <= 0, res_ready <= 1, timer <= 0, -> WAIT_RES.
  - start is ignored in every state except IDLE.
- State WAIT_RES:
  - timer increments every cycle.
  - On res_valid && res_ready: res_out <= res_data, res_out_valid <= 1 for exactly one cycle, recv_cnt++, res_ready <= 0.
  - Then, if buffer empty: done <= 1 (one cycle) -> IDLE.
  - Otherwise: a_out/b_out <= new head, op_valid <= 1 -> SEND.
  - Minimum operand-to-operand spacing is 2 cycles.
  - If timer reaches TIMEOUT-1 without a result handshake: -> ERR.
  - A result handshake on the same cycle as the timeout wins; no error.
- State ERR:
  - timeout_err=1, op_valid=0, res_ready=0, ld_ready=0; busy=0.
  - Stays until reset.
- busy = state in {SEND, WAIT_RES}.
- Counters saturate at DEPTH and hold their values in IDLE until the next accepted start.
- res_valid while res_ready==0 is ignored (not captured, not counted).
- Buffer is a circular FIFO; pointers wrap modulo DEPTH, and count distinguishes full from empty.

Test Plan:
1. Reset, load A=0x40400000 (3.0), B=0x40000000 (2.0), start; responder returns 0x40C00000 two cycles after op handshake -> op_valid one cycle after start with those operands, res_out=0x40C00000 with one res_out_valid pulse, sent_cnt=recv_cnt=1, done pulse, return to IDLE.
2. Load DEPTH=8 pairs, then a ninth with ld_valid=1 -> ld_ready=0 on the ninth, not stored; run -> exactly 8 results in load order, pointer wrap exercised on a second 8-pair run.
3. Hold op_ready=0 for 5 cycles in SEND -> a_out/b_out/op_valid stable throughout; single pop on first op_ready=1 edge.
4. No response after op handshake -> timeout_err=1 at cycle TIMEOUT (64) in WAIT_RES; busy=0; ld_ready=0; start ignored until rst=0.
5. Assert rst=0 in WAIT_RES with 3 pairs pending -> next cycle all outputs 0 and buffer empty; start after release ignored (empty).
6. In IDLE with empty buffer, assert ld_valid and start together -> pair loaded and SEND entered on the same edge, op_valid=1 next cycle with the loaded operands.
